// File: rtl/axi_lite_xbar_1ton.sv
// AXI-Lite 1-to-N address router; AR/AW captured in a register, route held until the response handshake.
// Latency: AR accept -> slave arvalid +1, -> rvalid +2 (zero-wait slave); one transaction per direction, R/B backpressure passes straight through.
module axi_lite_xbar_1ton #(
    parameter int                           NUM_SLAVES = 3,
    parameter int                           ADDR_W     = 32,
    parameter int                           DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h00000000, 32'h00010000, 32'h00018000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LEN    = {32'h00010000, 32'h00008000, 32'h0000000c},
    parameter logic [DATA_W-1:0]            ERR_RDATA  = 32'hDEADBEEF,
    parameter int                           ERRCNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              m_araddr,
    input  logic [2:0]                     m_arprot,
    input  logic                           m_arvalid,
    output logic                           m_arready,
    output logic [DATA_W-1:0]              m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rvalid,
    input  logic                           m_rready,
    input  logic [ADDR_W-1:0]              m_awaddr,
    input  logic [2:0]                     m_awprot,
    input  logic                           m_awvalid,
    output logic                           m_awready,
    input  logic [DATA_W-1:0]              m_wdata,
    input  logic [DATA_W/8-1:0]            m_wstrb,
    input  logic                           m_wvalid,
    output logic                           m_wready,
    output logic [1:0]                     m_bresp,
    output logic                           m_bvalid,
    input  logic                           m_bready,
    output logic [NUM_SLAVES*ADDR_W-1:0]   s_araddr,
    output logic [NUM_SLAVES*3-1:0]        s_arprot,
    output logic [NUM_SLAVES-1:0]          s_arvalid,
    input  logic [NUM_SLAVES-1:0]          s_arready,
    input  logic [NUM_SLAVES*DATA_W-1:0]   s_rdata,
    input  logic [NUM_SLAVES*2-1:0]        s_rresp,
    input  logic [NUM_SLAVES-1:0]          s_rvalid,
    output logic [NUM_SLAVES-1:0]          s_rready,
    output logic [NUM_SLAVES*ADDR_W-1:0]   s_awaddr,
    output logic [NUM_SLAVES*3-1:0]        s_awprot,
    output logic [NUM_SLAVES-1:0]          s_awvalid,
    input  logic [NUM_SLAVES-1:0]          s_awready,
    output logic [NUM_SLAVES*DATA_W-1:0]   s_wdata,
    output logic [NUM_SLAVES*DATA_W/8-1:0] s_wstrb,
    output logic [NUM_SLAVES-1:0]          s_wvalid,
    input  logic [NUM_SLAVES-1:0]          s_wready,
    input  logic [NUM_SLAVES*2-1:0]        s_bresp,
    input  logic [NUM_SLAVES-1:0]          s_bvalid,
    output logic [NUM_SLAVES-1:0]          s_bready,
    output logic                           decode_err,
    output logic [ADDR_W-1:0]              err_addr,
    output logic [ERRCNT_W-1:0]            err_count
);
    localparam int         STRB_W      = DATA_W / 8;
    localparam int         SEL_W       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA, RD_ERR} rd_state_t;
    typedef enum logic [2:0] {WR_IDLE, WR_FWD, WR_RESP, WR_ERR_W, WR_ERR_B} wr_state_t;

    rd_state_t         rd_state, rd_state_nxt;
    wr_state_t         wr_state, wr_state_nxt;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [2:0]        rd_prot, wr_prot;
    logic [SEL_W-1:0]  rd_sel, wr_sel;
    logic              aw_done, w_done, wr_aw_hs, wr_w_hs;
    logic [SEL_W:0]    ar_dec, aw_dec;
    logic              ar_fire, aw_fire, ar_err, aw_err;
    logic [ERRCNT_W:0] cnt_sum;

    // Slave 0 is the leftmost entry of the base/length tables; the lowest matching index wins.
    function automatic logic [SEL_W:0] decode(input logic [ADDR_W-1:0] addr);
        logic [SEL_W:0]    res;
        logic [ADDR_W-1:0] base, len;
        res = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            base = SLV_BASE[(NUM_SLAVES-1-i)*ADDR_W +: ADDR_W];
            len  = SLV_LEN[(NUM_SLAVES-1-i)*ADDR_W +: ADDR_W];
            if (addr >= base && (addr - base) < len)
                res = {1'b1, SEL_W'(i)};
        end
        return res;
    endfunction

    assign ar_dec  = decode(m_araddr);
    assign aw_dec  = decode(m_awaddr);
    assign ar_fire = m_arvalid && m_arready;
    assign aw_fire = m_awvalid && m_awready;
    assign ar_err  = ar_fire && !ar_dec[SEL_W];
    assign aw_err  = aw_fire && !aw_dec[SEL_W];
    assign cnt_sum = {1'b0, err_count} + {{ERRCNT_W{1'b0}}, ar_err} + {{ERRCNT_W{1'b0}}, aw_err};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state   <= RD_IDLE;
            wr_state   <= WR_IDLE;
            rd_addr    <= '0;
            rd_prot    <= '0;
            rd_sel     <= '0;
            wr_addr    <= '0;
            wr_prot    <= '0;
            wr_sel     <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            decode_err <= 1'b0;
            err_addr   <= '0;
            err_count  <= '0;
        end else begin
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
            if (ar_fire) begin
                rd_addr <= m_araddr;
                rd_prot <= m_arprot;
                rd_sel  <= ar_dec[SEL_W-1:0];
            end
            if (aw_fire) begin
                wr_addr <= m_awaddr;
                wr_prot <= m_awprot;
                wr_sel  <= aw_dec[SEL_W-1:0];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (wr_aw_hs) aw_done <= 1'b1;
                if (wr_w_hs)  w_done  <= 1'b1;
            end
            decode_err <= ar_err || aw_err;
            // A simultaneous AR/AW miss reports the read address.
            if (ar_err)      err_addr <= m_araddr;
            else if (aw_err) err_addr <= m_awaddr;
            if (ar_err || aw_err)
                err_count <= cnt_sum[ERRCNT_W] ? '1 : cnt_sum[ERRCNT_W-1:0];
        end
    end

    always_comb begin
        rd_state_nxt = rd_state;
        m_arready    = 1'b0;
        m_rvalid     = 1'b0;
        m_rdata      = '0;
        m_rresp      = '0;
        s_arvalid    = '0;
        s_araddr     = '0;
        s_arprot     = '0;
        s_rready     = '0;
        case (rd_state)
            RD_IDLE: begin
                m_arready = !rst;
                if (m_arvalid && !rst)
                    rd_state_nxt = ar_dec[SEL_W] ? RD_ADDR : RD_ERR;
            end
            RD_ADDR: begin
                s_arvalid[rd_sel]                 = 1'b1;
                s_araddr[rd_sel*ADDR_W +: ADDR_W] = rd_addr;
                s_arprot[rd_sel*3 +: 3]           = rd_prot;
                if (s_arready[rd_sel]) rd_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                m_rvalid         = s_rvalid[rd_sel];
                m_rdata          = s_rdata[rd_sel*DATA_W +: DATA_W];
                m_rresp          = s_rresp[rd_sel*2 +: 2];
                s_rready[rd_sel] = m_rready;
                if (s_rvalid[rd_sel] && m_rready) rd_state_nxt = RD_IDLE;
            end
            RD_ERR: begin
                m_rvalid = 1'b1;
                m_rdata  = ERR_RDATA;
                m_rresp  = RESP_DECERR;
                if (m_rready) rd_state_nxt = RD_IDLE;
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        m_awready    = 1'b0;
        m_wready     = 1'b0;
        m_bvalid     = 1'b0;
        m_bresp      = '0;
        s_awvalid    = '0;
        s_awaddr     = '0;
        s_awprot     = '0;
        s_wvalid     = '0;
        s_wdata      = '0;
        s_wstrb      = '0;
        s_bready     = '0;
        wr_aw_hs     = 1'b0;
        wr_w_hs      = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                m_awready = !rst;
                if (m_awvalid && !rst)
                    wr_state_nxt = aw_dec[SEL_W] ? WR_FWD : WR_ERR_W;
            end
            WR_FWD: begin
                s_awvalid[wr_sel]                 = !aw_done;
                s_awaddr[wr_sel*ADDR_W +: ADDR_W] = wr_addr;
                s_awprot[wr_sel*3 +: 3]           = wr_prot;
                if (!w_done) begin
                    s_wvalid[wr_sel]                  = m_wvalid;
                    s_wdata[wr_sel*DATA_W +: DATA_W]  = m_wdata;
                    s_wstrb[wr_sel*STRB_W +: STRB_W]  = m_wstrb;
                    m_wready                          = s_wready[wr_sel];
                end
                wr_aw_hs = !aw_done && s_awready[wr_sel];
                wr_w_hs  = !w_done && m_wvalid && s_wready[wr_sel];
                if ((aw_done || wr_aw_hs) && (w_done || wr_w_hs))
                    wr_state_nxt = WR_RESP;
            end
            WR_RESP: begin
                m_bvalid         = s_bvalid[wr_sel];
                m_bresp          = s_bresp[wr_sel*2 +: 2];
                s_bready[wr_sel] = m_bready;
                if (s_bvalid[wr_sel] && m_bready) wr_state_nxt = WR_IDLE;
            end
            WR_ERR_W: begin
                m_wready = 1'b1;
                if (m_wvalid) wr_state_nxt = WR_ERR_B;
            end
            WR_ERR_B: begin
                m_bvalid = 1'b1;
                m_bresp  = RESP_DECERR;
                if (m_bready) wr_state_nxt = WR_IDLE;
            end
            default: wr_state_nxt = WR_IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_xbar_1ton.sv
// Directed bench for the AXI-Lite 1-to-N router with three simple slave models.
// A second instance with a 2-bit error counter exercises counter saturation.
module tb_axi_lite_xbar_1ton;
    logic        clk, rst;
    logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata, err_addr;
    logic [2:0]  m_arprot, m_awprot;
    logic [3:0]  m_wstrb;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready, decode_err;
    logic [1:0]  m_rresp, m_bresp;
    logic [15:0] err_count;
    logic [95:0] s_araddr, s_awaddr, s_rdata, s_wdata;
    logic [8:0]  s_arprot, s_awprot;
    logic [11:0] s_wstrb;
    logic [5:0]  s_rresp, s_bresp;
    logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic [2:0]  s_wvalid, s_wready, s_bvalid, s_bready;

    // Outputs of the narrow-counter instance
    logic [31:0] sm_rdata, sm_err_addr;
    logic [1:0]  sm_rresp, sm_bresp, sm_err_count;
    logic        sm_arready, sm_rvalid, sm_awready, sm_wready, sm_bvalid, sm_decode_err;
    logic [95:0] sm_araddr, sm_awaddr, sm_wdata;
    logic [8:0]  sm_arprot, sm_awprot;
    logic [11:0] sm_wstrb;
    logic [2:0]  sm_arvalid, sm_rready, sm_awvalid, sm_wvalid, sm_bready;

    int checks = 0;
    int errors = 0;

    // Slave models: zero-wait AR and W, configurable AW stall, registered R and B.
    logic [2:0]  slv_rvalid, slv_bvalid, got_aw, got_w;
    int          aw_stall [3];
    int          aw_age   [3];
    int          ar_cnt   [3] = '{0, 0, 0};
    int          aw_cnt   [3] = '{0, 0, 0};
    int          w_cnt    [3] = '{0, 0, 0};
    int          b_cnt    [3] = '{0, 0, 0};
    logic [31:0] last_awaddr [3];
    logic [31:0] last_wdata  [3];
    logic [3:0]  last_wstrb  [3];
    logic        aw_hs, w_hs;

    assign s_rdata   = {32'h0000C002, 32'h12345678, 32'h0000A000};
    assign s_rresp   = '0;
    assign s_bresp   = '0;
    assign s_wready  = 3'b111;
    assign s_arready = s_arvalid;
    assign s_rvalid  = slv_rvalid;
    assign s_bvalid  = slv_bvalid;

    always_comb begin
        s_awready = '0;
        for (int i = 0; i < 3; i++)
            s_awready[i] = s_awvalid[i] && (aw_age[i] >= aw_stall[i]);
    end

    always @(posedge clk) begin
        if (rst) begin
            slv_rvalid <= '0;
            slv_bvalid <= '0;
            got_aw     <= '0;
            got_w      <= '0;
            for (int i = 0; i < 3; i++) aw_age[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                aw_hs = s_awvalid[i] && s_awready[i];
                w_hs  = s_wvalid[i] && s_wready[i];
                if (s_arvalid[i] && s_arready[i]) begin
                    slv_rvalid[i] <= 1'b1;
                    ar_cnt[i]     <= ar_cnt[i] + 1;
                end else if (s_rvalid[i] && s_rready[i]) begin
                    slv_rvalid[i] <= 1'b0;
                end
                if (aw_hs) begin
                    aw_age[i]      <= 0;
                    aw_cnt[i]      <= aw_cnt[i] + 1;
                    last_awaddr[i] <= s_awaddr[i*32 +: 32];
                end else if (s_awvalid[i]) begin
                    aw_age[i] <= aw_age[i] + 1;
                end
                if (w_hs) begin
                    w_cnt[i]      <= w_cnt[i] + 1;
                    last_wdata[i] <= s_wdata[i*32 +: 32];
                    last_wstrb[i] <= s_wstrb[i*4 +: 4];
                end
                if ((got_aw[i] || aw_hs) && (got_w[i] || w_hs)) begin
                    slv_bvalid[i] <= 1'b1;
                    got_aw[i]     <= 1'b0;
                    got_w[i]      <= 1'b0;
                end else begin
                    if (aw_hs) got_aw[i] <= 1'b1;
                    if (w_hs)  got_w[i]  <= 1'b1;
                end
                if (s_bvalid[i] && s_bready[i]) begin
                    slv_bvalid[i] <= 1'b0;
                    b_cnt[i]      <= b_cnt[i] + 1;
                end
            end
        end
    end

    axi_lite_xbar_1ton dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .decode_err(decode_err), .err_addr(err_addr), .err_count(err_count)
    );

    axi_lite_xbar_1ton #(.ERRCNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(sm_arready),
        .m_rdata(sm_rdata), .m_rresp(sm_rresp), .m_rvalid(sm_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(sm_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(sm_wready),
        .m_bresp(sm_bresp), .m_bvalid(sm_bvalid), .m_bready(m_bready),
        .s_araddr(sm_araddr), .s_arprot(sm_arprot), .s_arvalid(sm_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(sm_rready),
        .s_awaddr(sm_awaddr), .s_awprot(sm_awprot), .s_awvalid(sm_awvalid), .s_awready(s_awready),
        .s_wdata(sm_wdata), .s_wstrb(sm_wstrb), .s_wvalid(sm_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(sm_bready),
        .decode_err(sm_decode_err), .err_addr(sm_err_addr), .err_count(sm_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n, aw0, w0;
        rst = 1'b1;
        m_araddr = '0; m_arprot = '0; m_arvalid = 1'b0; m_rready = 1'b1;
        m_awaddr = '0; m_awprot = '0; m_awvalid = 1'b0;
        m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b1;
        aw_stall = '{0, 0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_arready", m_arready, 0);
        check("rst_awready", m_awready, 0);
        check("rst_m_valids", {m_rvalid, m_bvalid, m_wready}, 0);
        check("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid}, 0);
        check("rst_decode_err", decode_err, 0);
        check("rst_err_addr", err_addr, 0);
        check("rst_err_count", err_count, 0);
        step(); rst = 1'b0;
        @(negedge clk);
        check("post_rst_arready", m_arready, 1);
        check("post_rst_awready", m_awready, 1);

        // Read slave 1, zero-wait
        step(); m_araddr = 32'h00010004; m_arvalid = 1'b1;
        step(); m_arvalid = 1'b0;
        @(negedge clk);
        check("rd1_s_arvalid", s_arvalid, 3'b010);
        check("rd1_s_araddr", s_araddr[63:32], 32'h00010004);
        check("rd1_rvalid_early", m_rvalid, 0);
        step();
        @(negedge clk);
        check("rd1_rvalid", m_rvalid, 1);
        check("rd1_rdata", m_rdata, 32'h12345678);
        check("rd1_rresp", m_rresp, 0);
        step();
        @(negedge clk);
        check("rd1_rvalid_done", m_rvalid, 0);
        check("rd1_ar_cnt", {ar_cnt[2][7:0], ar_cnt[1][7:0], ar_cnt[0][7:0]}, 24'h000100);

        // Write slave 2 with W presented three cycles before AW
        step(); m_wvalid = 1'b1; m_wdata = 32'hA5A5A5A5; m_wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("wr1_wready_early", m_wready, 0);
            step();
        end
        m_awaddr = 32'h00018008; m_awvalid = 1'b1;
        @(negedge clk);
        check("wr1_wready_idle", m_wready, 0);
        step(); m_awvalid = 1'b0;
        @(negedge clk);
        check("wr1_s_awvalid", s_awvalid, 3'b100);
        check("wr1_s_wvalid", s_wvalid, 3'b100);
        check("wr1_wready", m_wready, 1);
        step(); m_wvalid = 1'b0;
        n = 0;
        while (!m_bvalid && n < 20) begin @(negedge clk); n++; end
        check("wr1_bvalid", m_bvalid, 1);
        check("wr1_bresp", m_bresp, 0);
        step();
        @(negedge clk);
        check("wr1_bvalid_done", m_bvalid, 0);
        check("wr1_b_cnt", b_cnt[2], 1);
        check("wr1_awaddr", last_awaddr[2], 32'h00018008);
        check("wr1_wdata", last_wdata[2], 32'hA5A5A5A5);
        check("wr1_wstrb", last_wstrb[2], 4'hF);
        check("wr1_err_count", err_count, 0);

        // Unmapped read
        step(); m_araddr = 32'h00020000; m_arvalid = 1'b1;
        step(); m_arvalid = 1'b0;
        @(negedge clk);
        check("rderr_rvalid", m_rvalid, 1);
        check("rderr_rdata", m_rdata, 32'hDEADBEEF);
        check("rderr_rresp", m_rresp, 2'b11);
        check("rderr_decode_err", decode_err, 1);
        check("rderr_err_addr", err_addr, 32'h00020000);
        check("rderr_err_count", err_count, 1);
        check("rderr_s_arvalid", s_arvalid, 0);
        step();
        @(negedge clk);
        check("rderr_pulse_end", decode_err, 0);
        check("rderr_rvalid_done", m_rvalid, 0);
        check("rderr_ar_cnt", {ar_cnt[2][7:0], ar_cnt[1][7:0], ar_cnt[0][7:0]}, 24'h000100);

        // Unmapped write one byte past the end of slave 2
        step(); m_awaddr = 32'h0001800C; m_awvalid = 1'b1; m_wvalid = 1'b1; m_wdata = 32'h1;
        step(); m_awvalid = 1'b0;
        @(negedge clk);
        check("wrerr_wready", m_wready, 1);
        check("wrerr_decode_err", decode_err, 1);
        check("wrerr_err_addr", err_addr, 32'h0001800C);
        check("wrerr_err_count", err_count, 2);
        check("wrerr_s_valids", {s_awvalid, s_wvalid}, 0);
        step(); m_wvalid = 1'b0;
        @(negedge clk);
        check("wrerr_bvalid", m_bvalid, 1);
        check("wrerr_bresp", m_bresp, 2'b11);
        step();
        @(negedge clk);
        check("wrerr_bvalid_done", m_bvalid, 0);

        // Concurrent read of slave 0 and write of slave 2 with a 5-cycle AW stall
        aw_stall[2] = 5;
        aw0 = aw_cnt[2]; w0 = w_cnt[2];
        step();
        m_araddr = 32'h00000100; m_arvalid = 1'b1;
        m_awaddr = 32'h00018004; m_awvalid = 1'b1;
        m_wvalid = 1'b1; m_wdata = 32'h0F0F0F0F; m_wstrb = 4'h3;
        step(); m_arvalid = 1'b0; m_awvalid = 1'b0;
        @(negedge clk);
        check("cc_s_arvalid", s_arvalid, 3'b001);
        check("cc_s_awvalid", s_awvalid, 3'b100);
        check("cc_wready", m_wready, 1);
        step(); m_wvalid = 1'b0;
        @(negedge clk);
        check("cc_rvalid", m_rvalid, 1);
        check("cc_rdata", m_rdata, 32'h0000A000);
        check("cc_bvalid_early", m_bvalid, 0);
        step();
        @(negedge clk);
        check("cc_rvalid_done", m_rvalid, 0);
        check("cc_aw_stalled", s_awvalid, 3'b100);
        check("cc_bvalid_stalled", m_bvalid, 0);
        n = 0;
        while (!m_bvalid && n < 20) begin @(negedge clk); n++; end
        check("cc_bvalid", m_bvalid, 1);
        check("cc_b_delay", n, 4);
        check("cc_aw_before_b", aw_cnt[2] - aw0, 1);
        check("cc_w_before_b", w_cnt[2] - w0, 1);
        check("cc_awaddr", last_awaddr[2], 32'h00018004);
        check("cc_wstrb", last_wstrb[2], 4'h3);
        step(); aw_stall[2] = 0;

        // R backpressure from the master for 4 cycles on a slave 1 read
        step(); m_araddr = 32'h00010008; m_arvalid = 1'b1; m_rready = 1'b0;
        step(); m_arvalid = 1'b0;
        step(); m_araddr = 32'h00000000; m_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_rvalid", m_rvalid, 1);
            check("bp_rdata", m_rdata, 32'h12345678);
            check("bp_s_rready", s_rready, 0);
            check("bp_arready", m_arready, 0);
            step();
        end
        m_arvalid = 1'b0; m_rready = 1'b1;
        @(negedge clk);
        check("bp_s_rready_on", s_rready, 3'b010);
        step();
        @(negedge clk);
        check("bp_rvalid_done", m_rvalid, 0);
        check("bp_ar_cnt", {ar_cnt[2][7:0], ar_cnt[1][7:0], ar_cnt[0][7:0]}, 24'h000201);

        // Reset while the read sits in RD_DATA and the write in WR_FWD
        aw_stall[2] = 10;
        step();
        m_araddr = 32'h00010000; m_arvalid = 1'b1; m_rready = 1'b0;
        m_awaddr = 32'h00018000; m_awvalid = 1'b1;
        step(); m_arvalid = 1'b0; m_awvalid = 1'b0;
        step();
        @(negedge clk);
        check("mr_pre_rvalid", m_rvalid, 1);
        check("mr_pre_awvalid", s_awvalid, 3'b100);
        step(); rst = 1'b1;
        step();
        @(negedge clk);
        check("mr_m_valids", {m_rvalid, m_bvalid, m_wready, m_arready, m_awready}, 0);
        check("mr_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        check("mr_err_count", err_count, 0);
        step(); rst = 1'b0; aw_stall[2] = 0; m_rready = 1'b1;
        m_araddr = 32'h00000000; m_arvalid = 1'b1;
        step(); m_arvalid = 1'b0;
        step();
        @(negedge clk);
        check("mr_rd_rvalid", m_rvalid, 1);
        check("mr_rd_rdata", m_rdata, 32'h0000A000);
        step();
        @(negedge clk);
        check("mr_rd_done", m_rvalid, 0);

        // AR and AW both unmapped in the same cycle
        step();
        m_araddr = 32'h00030000; m_arvalid = 1'b1;
        m_awaddr = 32'h00040000; m_awvalid = 1'b1; m_wvalid = 1'b1;
        step(); m_arvalid = 1'b0; m_awvalid = 1'b0;
        @(negedge clk);
        check("dbl_decode_err", decode_err, 1);
        check("dbl_err_addr", err_addr, 32'h00030000);
        check("dbl_err_count", err_count, 2);
        check("dbl_sat_count", sm_err_count, 2);
        check("dbl_rvalid", m_rvalid, 1);
        check("dbl_wready", m_wready, 1);
        step(); m_wvalid = 1'b0;
        @(negedge clk);
        check("dbl_pulse_once", decode_err, 0);
        check("dbl_bvalid", m_bvalid, 1);
        check("dbl_bresp", m_bresp, 2'b11);
        step();
        for (int k = 0; k < 2; k++) begin
            step(); m_araddr = 32'h00050000; m_arvalid = 1'b1;
            step(); m_arvalid = 1'b0;
            step();
        end
        @(negedge clk);
        check("sat_err_count", err_count, 4);
        check("sat_sat_count", sm_err_count, 3);
        check("sat_err_addr", err_addr, 32'h00050000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/axi_lite_xbar_1ton.md
Name: axi_lite_xbar_1toN

Overview:
- Parametrised 1-master to NUM_SLAVES-slave AXI-Lite address router with registered AR/AW capture and per-direction transaction locking.
- The route is fixed from address acceptance until the response handshake.
- Unmapped addresses are absorbed locally with a defined error response, and a decode-error pulse, last-error address and saturating counter are reported.
- Sits between the CPU bus master and the ROM/RAM/peripheral slaves, replacing the fixed two-slave combinational mux.

Parameters:
- NUM_SLAVES, 3, number of slave ports (1..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- SLV_BASE, {32'h00000000, 32'h00010000, 32'h00018000}, base address per slave, packed array [NUM_SLAVES].
- SLV_LEN, {32'h00010000, 32'h00008000, 32'h0000000c}, region length in bytes per slave; 0 disables the region.
- ERR_RDATA, 32'hDEADBEEF, rdata returned for unmapped reads.
- ERRCNT_W, 16, width of the error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- master_axi  axi_interf.master  -  upstream AXI-Lite (AR/R/AW/W/B, prot, strb).
- slave_axi[NUM_SLAVES]  axi_interf.slave  -  downstream AXI-Lite ports.
- decode_err  out  1  one-cycle pulse on an unmapped AR or AW acceptance.
- err_addr  out  ADDR_W  address of the most recent unmapped access.
- err_count  out  ERRCNT_W  saturating count of unmapped accesses.

Behaviour:
- Decode: hit[i] = (addr >= SLV_BASE[i]) && (addr - SLV_BASE[i] < SLV_LEN[i]). The subtraction form avoids top-of-map overflow. The lowest matching index wins on overlap. No hit = unmapped.

Read FSM (RD_IDLE, RD_ADDR, RD_DATA, RD_ERR):
- RD_IDLE:
  - master arready=1.
  - On arvalid&&arready: latch araddr, arprot and the decode.
  - Next state is RD_ADDR if mapped, else RD_ERR.
- RD_ADDR:
  - slave[sel].arvalid=1 with the latched addr/prot; all other slaves' arvalid=0.
  - On slave arready, go to RD_DATA.
- RD_DATA:
  - R channel passes through combinationally from slave[sel] (rvalid, rdata; rready back).
  - On rvalid&&rready, go to RD_IDLE.
- RD_ERR:
  - master rvalid=1, rdata=ERR_RDATA, held until rready; then go to RD_IDLE.
- Minimum read latency: AR accept to rvalid is 2 cycles with a zero-wait slave. Maximum sustained rate is one read per 3 cycles.

Write FSM (WR_IDLE, WR_FWD, WR_RESP, WR_ERR_W, WR_ERR_B):
- WR_IDLE:
  - master awready=1, wready=0 (W is never accepted before AW).
  - On AW handshake: latch awaddr, awprot and the decode; clear aw_done and w_done.
  - Next state is WR_FWD if mapped, else WR_ERR_W.
- WR_FWD:
  - slave[sel].awvalid = !aw_done with the latched fields; set aw_done on slave awready.
  - W routes combinationally master->slave[sel] while !w_done (wvalid, wdata, wstrb; wready back); set w_done on the handshake.
  - AW and W complete in either order or the same cycle. When both are done (including same-cycle completion), go to WR_RESP.
- WR_RESP:
  - B passes through from slave[sel]; on bvalid&&bready, go to WR_IDLE.
- WR_ERR_W:
  - master wready=1; data is discarded; on the W handshake go to WR_ERR_B.
- WR_ERR_B:
  - master bvalid=1 until bready; then go to WR_IDLE.

Independence and idle signal values:
- The read and write FSMs are independent; concurrent read and write to different or the same slaves are allowed.
- At most one outstanding transaction per direction.
- Unselected slave ports drive valid=0, ready=0 and address/data=0.
- Master outputs not named above are 0.

Error reporting:
- decode_err=1 for the cycle after an unmapped AR or AW acceptance.
- If AR and AW are both unmapped in the same cycle: decode_err pulses once, err_count increments by 2 (saturating), and err_addr takes the AR address.
- err_count saturates at all-ones; it does not wrap.

Reset:
- Both FSMs go to IDLE; all valid/ready outputs are 0, except that awready and arready read 1 from the first cycle after reset deasserts.
- decode_err=0, err_addr=0, err_count=0.
- Reset mid-transaction abandons it with no response; slaves are reset by the same rst.

Test Plan:
- Read 0x00010004 (slave1, rdata 0x12345678, zero-wait) -> slave1 arvalid with araddr 0x00010004 one cycle after accept; master rvalid=1 with rdata 0x12345678 two cycles after accept; slaves 0 and 2 see no arvalid.
- Write 0x00018008, data 0xA5A5A5A5, strb 4'hF, with W presented 3 cycles before AW -> wready=0 until AW is accepted; slave2 gets AW and W; one B returned; err_count=0.
- Read 0x00020000 (unmapped) -> rvalid with rdata 0xDEADBEEF; decode_err pulse; err_addr=0x00020000; err_count=1; no slave arvalid.
- Simultaneous read of slave0 and write of slave2, where slave2 stalls awready 5 cycles -> read completes unaffected; write B occurs only after both AW and W handshakes.
- Master holds rready=0 for 4 cycles during a slave1 read -> rdata stable, slave1 rready=0; a new arvalid is not accepted until R completes.
- Assert rst in RD_DATA and WR_FWD -> next cycle all valids are 0, err_count=0; a subsequent read of 0x0 completes normally.
